atm_request_gen: RTL

- Customer-side front end for the ATM core: the initiator that drives transactions into the core, which is the responder.
- Takes single-cycle keypad key events and assembles a 4-digit PIN and a decimal amount.
- Issues authentication and transaction requests to the core over a valid/ready handshake, then waits for the core's response.
- Tracks failed PIN attempts, locks the session after too many failures, and aborts idle sessions on timeout.

---
 rtl/atm_request_gen.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/atm_request_gen.sv
`default_nettype none
// ============================================================================
// Module  : atm_request_gen
// Purpose : Keypad front end that builds AUTH/transaction requests for the ATM core.
// Rev     : 1.0
// ============================================================================
module atm_request_gen #(
  parameter int MAX_TRIES      = 3,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int AMT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  output logic             req_valid,
  output logic [2:0]       req_op,
  output logic [15:0]      req_pin,
  output logic [AMT_W-1:0] req_amount,
  input  logic             req_ready,
  input  logic             resp_valid,
  input  logic             resp_ok,
  output logic             session_active,
  output logic             locked,
  output logic             key_err,
  output logic             timeout
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int FW = $clog2(MAX_TRIES + 1);

  localparam logic [3:0] c_key_a = 4'hA;
  localparam logic [3:0] c_key_b = 4'hB;
  localparam logic [3:0] c_key_c = 4'hC;
  localparam logic [3:0] c_key_d = 4'hD;
  localparam logic [3:0] c_key_e = 4'hE;
  localparam logic [3:0] c_key_f = 4'hF;

  localparam logic [2:0] c_op_auth  = 3'd1;
  localparam logic [2:0] c_op_wdraw = 3'd2;
  localparam logic [2:0] c_op_dep   = 3'd3;
  localparam logic [2:0] c_op_bal   = 3'd4;
  localparam logic [2:0] c_op_mini  = 3'd5;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_PIN       = 4'd1,
    S_SEND_AUTH = 4'd2,
    S_WAIT_AUTH = 4'd3,
    S_MENU      = 4'd4,
    S_AMT       = 4'd5,
    S_SEND_TXN  = 4'd6,
    S_WAIT_TXN  = 4'd7,
    S_LOCKED    = 4'd8
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      pin_q, pin_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [AMT_W-1:0] amt_q, amt_d;
  logic [2:0]       op_q, op_d;
  logic [FW-1:0]    fail_q, fail_d;
  logic [TW-1:0]    timer_q, timer_d;

  logic             w_digit;
  logic [AMT_W+3:0] w_amt_ext;
  logic             w_amt_ovf;
  logic             w_timed;
  logic             w_stay;

  assign w_digit   = (key_code <= 4'd9);
  assign w_amt_ext = ({4'b0, amt_q} << 3) + ({4'b0, amt_q} << 1)
                   + {{AMT_W{1'b0}}, key_code};
  assign w_amt_ovf = |w_amt_ext[AMT_W+3:AMT_W];
  assign w_timed   = (state_q == S_PIN) || (state_q == S_MENU) || (state_q == S_AMT) ||
                     (state_q == S_WAIT_AUTH) || (state_q == S_WAIT_TXN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pin_q   <= '0;
      cnt_q   <= '0;
      amt_q   <= '0;
      op_q    <= '0;
      fail_q  <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      pin_q   <= pin_d;
      cnt_q   <= cnt_d;
      amt_q   <= amt_d;
      op_q    <= op_d;
      fail_q  <= fail_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pin_d   = pin_q;
    cnt_d   = cnt_q;
    amt_d   = amt_q;
    op_d    = op_q;
    fail_d  = fail_q;
    timer_d = timer_q;
    key_err = 1'b0;
    timeout = 1'b0;
    w_stay  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (key_valid) begin
          if (w_digit) begin
            pin_d   = {key_code, 12'h000};
            cnt_d   = 3'd1;
            state_d = S_PIN;
          end else begin
            key_err = 1'b1;
          end
        end
      end
      S_PIN: begin
        if (key_valid) begin
          if (w_digit) begin
            if (cnt_q < 3'd4) begin
              case (cnt_q)
                3'd1:    pin_d[11:8] = key_code;
                3'd2:    pin_d[7:4]  = key_code;
                3'd3:    pin_d[3:0]  = key_code;
                default: pin_d[15:12] = key_code;
              endcase
              cnt_d = cnt_q + 3'd1;
            end else begin
              key_err = 1'b1;
            end
          end else if (key_code == c_key_e && cnt_q == 3'd4) begin
            op_d    = c_op_auth;
            amt_d   = '0;
            state_d = S_SEND_AUTH;
          end else if (key_code == c_key_f) begin
            pin_d   = '0;
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            key_err = 1'b1;
          end
        end
      end
      S_SEND_AUTH: if (req_ready) state_d = S_WAIT_AUTH;
      S_WAIT_AUTH: begin
        if (resp_valid) begin
          if (resp_ok) begin
            fail_d  = '0;
            state_d = S_MENU;
          end else begin
            fail_d = fail_q + 1'b1;
            pin_d  = '0;
            cnt_d  = '0;
            state_d = (fail_q == FW'(MAX_TRIES - 1)) ? S_LOCKED : S_IDLE;
          end
        end
      end
      S_MENU: begin
        if (key_valid) begin
          if (key_code == c_key_a || key_code == c_key_b) begin
            op_d    = (key_code == c_key_a) ? c_op_wdraw : c_op_dep;
            amt_d   = '0;
            state_d = S_AMT;
          end else if (key_code == c_key_c || key_code == c_key_d) begin
            op_d    = (key_code == c_key_c) ? c_op_bal : c_op_mini;
            amt_d   = '0;
            state_d = S_SEND_TXN;
          end else if (key_code == c_key_f) begin
            pin_d   = '0;
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            key_err = 1'b1;
          end
        end
      end
      S_AMT: begin
        if (key_valid) begin
          if (w_digit) begin
            if (w_amt_ovf) key_err = 1'b1;
            else           amt_d   = w_amt_ext[AMT_W-1:0];
          end else if (key_code == c_key_e && amt_q != '0) begin
            state_d = S_SEND_TXN;
          end else if (key_code == c_key_f) begin
            state_d = S_MENU;
          end else begin
            key_err = 1'b1;
          end
        end
      end
      S_SEND_TXN: if (req_ready) state_d = S_WAIT_TXN;
      S_WAIT_TXN: if (resp_valid) state_d = S_MENU;
      S_LOCKED:   state_d = S_LOCKED;
      default:    state_d = S_IDLE;
    endcase

    // The idle count includes the current cycle, so the abort lands on the
    // cycle where that count reaches TIMEOUT_CYCLES-1.
    w_stay = (state_d == state_q);
    if (w_timed && !key_valid && w_stay && timer_q == TW'(TIMEOUT_CYCLES - 2)) begin
      timeout = 1'b1;
      pin_d   = '0;
      cnt_d   = '0;
      amt_d   = '0;
      state_d = S_IDLE;
      w_stay  = 1'b0;
    end

    timer_d = (!w_timed || key_valid || !w_stay) ? '0 : timer_q + 1'b1;
  end

  assign req_valid      = (state_q == S_SEND_AUTH) || (state_q == S_SEND_TXN);
  assign req_op         = req_valid ? op_q : 3'd0;
  assign req_pin        = pin_q;
  assign req_amount     = (state_q == S_SEND_TXN) ? amt_q : '0;
  assign session_active = (state_q == S_MENU) || (state_q == S_AMT) ||
                          (state_q == S_SEND_TXN) || (state_q == S_WAIT_TXN);
  assign locked         = (state_q == S_LOCKED);

endmodule
`default_nettype wire
